// File: rtl/ras_ckpt_if.sv
// -----------------------------------------------------------------------------
// ras_ckpt_if
//   Bundle between the fetch-stage predictor and the return-address stack.
//
//   Strobe semantics (there is no valid/ready pair): push, pop, ckpt_save and
//   ckpt_restore are single-cycle commands sampled on the rising clock edge.
//   The stack always accepts them and never back-pressures. A command that
//   cannot take effect (for example, a pop on an empty stack) is reported
//   through the overflow/underflow pulses.
//
//   master : predictor side. Drives commands and observes the stack status.
//   slave  : stack side (ras_ckpt).
//
//   Signals
//     push / push_addr            call: push return address
//     pop                         return: pop top entry
//     ckpt_save / ckpt_save_id    snapshot the stack top into a slot
//     ckpt_restore / _id          repair the stack from a slot
//     ret_addr                    predicted return address (entry at the top)
//     ret_valid / empty / full    occupancy status
//     overflow / underflow        registered one-cycle event pulses
//     dbg_count                   current occupancy, for observability
// -----------------------------------------------------------------------------
interface ras_ckpt_if #(
   parameter int PC_WIDTH = 32,
   parameter int ASIZE    = 3,
   parameter int CW       = 2
);
   logic                push;
   logic [PC_WIDTH-1:0] push_addr;
   logic                pop;
   logic                ckpt_save;
   logic [CW-1:0]       ckpt_save_id;
   logic                ckpt_restore;
   logic [CW-1:0]       ckpt_restore_id;
   logic [PC_WIDTH-1:0] ret_addr;
   logic                ret_valid;
   logic                empty;
   logic                full;
   logic                overflow;
   logic                underflow;
   logic [ASIZE:0]      dbg_count;

   modport master (
      output push, push_addr, pop,
      output ckpt_save, ckpt_save_id, ckpt_restore, ckpt_restore_id,
      input  ret_addr, ret_valid, empty, full, overflow, underflow, dbg_count
   );

   modport slave (
      input  push, push_addr, pop,
      input  ckpt_save, ckpt_save_id, ckpt_restore, ckpt_restore_id,
      output ret_addr, ret_valid, empty, full, overflow, underflow, dbg_count
   );
endinterface

// File: rtl/ras_ckpt.sv
// -----------------------------------------------------------------------------
// ras_ckpt
//   Return-address stack for the fetch-stage predictor, with checkpoint and
//   repair support.
//   - A call pushes a return address. A return pops one. A call and a return
//     in the same cycle replace the top entry.
//   - When the stack is full, a push either overwrites the oldest entry
//     (OVERWRITE=1) or is dropped (OVERWRITE=0). Both cases raise overflow.
//   - NCKPT slots each hold {tosp, count, top entry}. On a branch mispredict,
//     a slot can restore the stack top.
//
//   Ports
//     clk    rising-edge clock
//     rst_b  asynchronous active-low reset
//     ras    ras_ckpt_if.slave (commands in, status out)
// -----------------------------------------------------------------------------
module ras_ckpt #(
   parameter int PC_WIDTH  = 32,
   parameter int ASIZE     = 3,
   parameter int NCKPT     = 4,
   parameter bit OVERWRITE = 1'b1
) (
   input  logic       clk,
   input  logic       rst_b,
   ras_ckpt_if.slave  ras
);
   localparam int DEPTH = 1 << ASIZE;
   localparam int CW    = $clog2(NCKPT);
   localparam logic [ASIZE:0] COUNT_FULL = (ASIZE+1)'(DEPTH);

   logic [PC_WIDTH-1:0] stack_q [DEPTH];
   logic [PC_WIDTH-1:0] stack_d [DEPTH];
   logic [ASIZE-1:0]    tosp_q, tosp_d;
   logic [ASIZE:0]      count_q, count_d;
   logic                overflow_q, overflow_d;
   logic                underflow_q, underflow_d;

   logic [ASIZE-1:0]    slot_tosp_q  [NCKPT];
   logic [ASIZE-1:0]    slot_tosp_d  [NCKPT];
   logic [ASIZE:0]      slot_count_q [NCKPT];
   logic [ASIZE:0]      slot_count_d [NCKPT];
   logic [PC_WIDTH-1:0] slot_top_q   [NCKPT];
   logic [PC_WIDTH-1:0] slot_top_d   [NCKPT];

   logic                is_empty;
   logic                is_full;
   logic [ASIZE-1:0]    tosp_inc;
   logic [ASIZE-1:0]    rid_tosp;

   assign is_empty = (count_q == '0);
   assign is_full  = (count_q == COUNT_FULL);
   // The pointer width equals log2(DEPTH), so +1 and -1 wrap modulo DEPTH.
   assign tosp_inc = tosp_q + ASIZE'(1);
   assign rid_tosp = slot_tosp_q[ras.ckpt_restore_id];

   always_comb begin
      stack_d      = stack_q;
      tosp_d       = tosp_q;
      count_d      = count_q;
      slot_tosp_d  = slot_tosp_q;
      slot_count_d = slot_count_q;
      slot_top_d   = slot_top_q;
      overflow_d   = 1'b0;
      underflow_d  = 1'b0;

      if (ras.ckpt_restore) begin
         // Repair takes priority. The push, pop and save of this cycle are discarded.
         // Only the top entry is rewritten. Deeper entries clobbered since
         // the save stay as they are.
         tosp_d            = rid_tosp;
         count_d           = slot_count_q[ras.ckpt_restore_id];
         stack_d[rid_tosp] = slot_top_q[ras.ckpt_restore_id];
      end else begin
         // The snapshot uses the pre-edge state, so this cycle's push or pop is not included.
         if (ras.ckpt_save) begin
            slot_tosp_d[ras.ckpt_save_id]  = tosp_q;
            slot_count_d[ras.ckpt_save_id] = count_q;
            slot_top_d[ras.ckpt_save_id]   = stack_q[tosp_q];
         end

         if (ras.push && ras.pop && !is_empty) begin
            // Call-through-return: replace the top entry in place.
            stack_d[tosp_q] = ras.push_addr;
         end else if (ras.push) begin
            // A plain push. A push+pop on an empty stack also takes this path.
            if (!is_full) begin
               stack_d[tosp_inc] = ras.push_addr;
               tosp_d            = tosp_inc;
               count_d           = count_q + (ASIZE+1)'(1);
            end else begin
               overflow_d = 1'b1;
               if (OVERWRITE) begin
                  // The write lands on the oldest slot. Count stays at DEPTH.
                  stack_d[tosp_inc] = ras.push_addr;
                  tosp_d            = tosp_inc;
               end
            end
         end else if (ras.pop) begin
            if (!is_empty) begin
               tosp_d  = tosp_q - ASIZE'(1);
               count_d = count_q - (ASIZE+1)'(1);
            end else begin
               underflow_d = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         for (int i = 0; i < DEPTH; i++) stack_q[i] <= '0;
         for (int k = 0; k < NCKPT; k++) begin
            slot_tosp_q[k]  <= '1;
            slot_count_q[k] <= '0;
            slot_top_q[k]   <= '0;
         end
         tosp_q      <= '1;
         count_q     <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         stack_q      <= stack_d;
         slot_tosp_q  <= slot_tosp_d;
         slot_count_q <= slot_count_d;
         slot_top_q   <= slot_top_d;
         tosp_q       <= tosp_d;
         count_q      <= count_d;
         overflow_q   <= overflow_d;
         underflow_q  <= underflow_d;
      end
   end

   assign ras.ret_addr  = stack_q[tosp_q];
   assign ras.ret_valid = !is_empty;
   assign ras.empty     = is_empty;
   assign ras.full      = is_full;
   assign ras.overflow  = overflow_q;
   assign ras.underflow = underflow_q;
   assign ras.dbg_count = count_q;

   // Keeps the declared slot-id width tied to NCKPT.
   logic [CW-1:0] unused_cw;
   assign unused_cw = ras.ckpt_save_id ^ ras.ckpt_restore_id;
   logic unused_ok;
   assign unused_ok = ^unused_cw;
endmodule

// File: tb/tb_ras_ckpt.sv
module tb_ras_ckpt;
   localparam int PW = 32;
   localparam int AS = 2;
   localparam int CW = 2;

   logic clk;
   logic rst_b;

   ras_ckpt_if #(.PC_WIDTH(PW), .ASIZE(AS), .CW(CW)) ra ();
   ras_ckpt_if #(.PC_WIDTH(PW), .ASIZE(AS), .CW(CW)) rb ();

   ras_ckpt #(.PC_WIDTH(PW), .ASIZE(AS), .NCKPT(4), .OVERWRITE(1'b1)) u_dut_ow (
      .clk(clk), .rst_b(rst_b), .ras(ra.slave));
   ras_ckpt #(.PC_WIDTH(PW), .ASIZE(AS), .NCKPT(4), .OVERWRITE(1'b0)) u_dut_drop (
      .clk(clk), .rst_b(rst_b), .ras(rb.slave));

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   logic [PW-1:0] exp_q[$];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // scoreboard: expected ret_addr is queued when a step is driven
   task automatic sb_expect(input logic [PW-1:0] v);
      exp_q.push_back(v);
   endtask

   task automatic sb_check(input string tag, input logic [PW-1:0] obs);
      logic [PW-1:0] e;
      if (exp_q.size() == 0) begin
         checks++;
         failures++;
         $error("FAIL %s observed=%0h expected=<empty scoreboard>", tag, obs);
      end else begin
         e = exp_q.pop_front();
         chk(tag, {32'b0, obs}, {32'b0, e});
      end
   endtask

   task automatic idle_all();
      ra.push = 0; ra.push_addr = '0; ra.pop = 0;
      ra.ckpt_save = 0; ra.ckpt_save_id = '0; ra.ckpt_restore = 0; ra.ckpt_restore_id = '0;
      rb.push = 0; rb.push_addr = '0; rb.pop = 0;
      rb.ckpt_save = 0; rb.ckpt_save_id = '0; rb.ckpt_restore = 0; rb.ckpt_restore_id = '0;
   endtask

   task automatic do_reset();
      rst_b = 1'b0;
      repeat (2) @(posedge clk);
      #2 rst_b = 1'b1;
      exp_q.delete();
   endtask

   // driver: one clock cycle on the OVERWRITE=1 instance; outputs sampled #1 after the edge
   task automatic step_a(input logic p, input logic [PW-1:0] a, input logic po,
                         input logic sv, input logic [1:0] sid,
                         input logic rs, input logic [1:0] rid);
      ra.push = p; ra.push_addr = a; ra.pop = po;
      ra.ckpt_save = sv; ra.ckpt_save_id = sid;
      ra.ckpt_restore = rs; ra.ckpt_restore_id = rid;
      @(posedge clk);
      #1;
      idle_all();
   endtask

   task automatic push_a(input logic [PW-1:0] a);
      step_a(1, a, 0, 0, 2'd0, 0, 2'd0);
   endtask

   task automatic pop_a();
      step_a(0, '0, 1, 0, 2'd0, 0, 2'd0);
   endtask

   task automatic push_b(input logic [PW-1:0] a);
      rb.push = 1; rb.push_addr = a;
      @(posedge clk);
      #1;
      idle_all();
   endtask

   initial begin
      #20000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_b = 1'b1;
      idle_all();
      @(negedge clk);
      do_reset();

      // reset state
      chk("rst_ret_addr", ra.ret_addr, 0);
      chk("rst_ret_valid", ra.ret_valid, 0);
      chk("rst_empty", ra.empty, 1);
      chk("rst_full", ra.full, 0);
      chk("rst_overflow", ra.overflow, 0);
      chk("rst_underflow", ra.underflow, 0);
      chk("rst_count", ra.dbg_count, 0);

      // 1: pop on empty gives an underflow pulse
      pop_a();
      chk("t1_empty", ra.empty, 1);
      chk("t1_ret_valid", ra.ret_valid, 0);
      chk("t1_ret_addr", ra.ret_addr, 0);
      chk("t1_underflow", ra.underflow, 1);
      chk("t1_count", ra.dbg_count, 0);
      step_a(0, '0, 0, 0, 2'd0, 0, 2'd0);
      chk("t1_underflow_drop", ra.underflow, 0);

      // 2: fill, then drain
      for (int i = 0; i < 4; i++) begin
         sb_expect(32'h100 + 32'(4 * i));
         push_a(32'h100 + 32'(4 * i));
         sb_check("t2_push_ret", ra.ret_addr);
      end
      chk("t2_full", ra.full, 1);
      chk("t2_overflow", ra.overflow, 0);
      for (int i = 0; i < 3; i++) begin
         sb_expect(32'h108 - 32'(4 * i));
         pop_a();
         sb_check("t2_pop_ret", ra.ret_addr);
      end
      pop_a();
      chk("t2_empty", ra.empty, 1);
      chk("t2_underflow", ra.underflow, 0);

      // 3: overflow policies (both instances share the reset)
      do_reset();
      for (int i = 0; i < 5; i++) begin
         sb_expect(32'h100 + 32'(4 * i));
         push_a(32'h100 + 32'(4 * i));
         sb_check("t3_ow_push_ret", ra.ret_addr);
      end
      chk("t3_ow_overflow", ra.overflow, 1);
      chk("t3_ow_full", ra.full, 1);
      chk("t3_ow_count", ra.dbg_count, 4);
      step_a(0, '0, 0, 0, 2'd0, 0, 2'd0);
      chk("t3_ow_overflow_drop", ra.overflow, 0);
      for (int i = 0; i < 3; i++) begin
         sb_expect(32'h10C - 32'(4 * i));
         pop_a();
         sb_check("t3_ow_pop_ret", ra.ret_addr);
      end
      pop_a();
      chk("t3_ow_empty", ra.empty, 1);

      for (int i = 0; i < 5; i++) begin
         push_b(32'h100 + 32'(4 * i));
         if (i == 3) chk("t3_drop_pre_overflow", rb.overflow, 0);
      end
      chk("t3_drop_overflow", rb.overflow, 1);
      chk("t3_drop_ret", rb.ret_addr, 32'h10C);
      chk("t3_drop_count", rb.dbg_count, 4);
      push_b(32'h0);  // second dropped push: overflow stays asserted for this event
      chk("t3_drop_ret2", rb.ret_addr, 32'h10C);
      rb.push = 0;
      @(posedge clk); #1;
      chk("t3_drop_overflow_drop", rb.overflow, 0);

      // 4: call-through-return
      do_reset();
      push_a(32'h100);
      push_a(32'h104);
      sb_expect(32'h200);
      step_a(1, 32'h200, 1, 0, 2'd0, 0, 2'd0);
      sb_check("t4_pp_ret", ra.ret_addr);
      chk("t4_pp_count", ra.dbg_count, 2);
      chk("t4_pp_overflow", ra.overflow, 0);
      sb_expect(32'h100);
      pop_a();
      sb_check("t4_pop_ret", ra.ret_addr);
      pop_a();
      chk("t4_empty", ra.empty, 1);
      sb_expect(32'h300);
      step_a(1, 32'h300, 1, 0, 2'd0, 0, 2'd0);
      sb_check("t4_pp_empty_ret", ra.ret_addr);
      chk("t4_pp_empty_count", ra.dbg_count, 1);
      chk("t4_pp_empty_underflow", ra.underflow, 0);

      // 5: checkpoint/repair; the save shares its cycle with a pop (pre-edge state saved)
      do_reset();
      push_a(32'h100);
      push_a(32'h104);
      sb_expect(32'h100);
      step_a(0, '0, 1, 1, 2'd1, 0, 2'd0);
      sb_check("t5_pop_ret", ra.ret_addr);
      sb_expect(32'h300);
      push_a(32'h300);
      sb_check("t5_push_ret", ra.ret_addr);
      sb_expect(32'h104);
      step_a(0, '0, 0, 0, 2'd0, 1, 2'd1);
      sb_check("t5_restore_ret", ra.ret_addr);
      chk("t5_restore_count", ra.dbg_count, 2);
      sb_expect(32'h100);
      pop_a();
      sb_check("t5_after_pop_ret", ra.ret_addr);

      // 6: restore discards the same-cycle push; async reset mid-cycle
      push_a(32'h104);
      push_a(32'h600);
      chk("t6_pre_count", ra.dbg_count, 3);
      sb_expect(32'h104);
      step_a(1, 32'h500, 0, 0, 2'd0, 1, 2'd1);
      sb_check("t6_restore_ret", ra.ret_addr);
      chk("t6_restore_count", ra.dbg_count, 2);
      chk("t6_restore_overflow", ra.overflow, 0);
      push_a(32'h700);
      #2 rst_b = 1'b0;
      #1;
      chk("t6_rst_ret_addr", ra.ret_addr, 0);
      chk("t6_rst_empty", ra.empty, 1);
      chk("t6_rst_count", ra.dbg_count, 0);
      @(negedge clk);
      rst_b = 1'b1;
      // After reset, a slot holds {tosp='1, count=0, top=0}.
      step_a(0, '0, 0, 0, 2'd0, 1, 2'd1);
      chk("t6_slot_rst_empty", ra.empty, 1);
      chk("t6_slot_rst_ret", ra.ret_addr, 0);

      chk("sb_drained", 64'(exp_q.size()), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
